// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decode-permutation sequencer.
package decoder_pkg;

    localparam int NUM_ROUNDS_DEF = 24;
    localparam int NUM_STAGES     = 5;

    // Controller states; the encoding is visible on the debug port.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LD_RC  = 4'd1,
        S_W_RC   = 4'd2,
        S_LD_REV = 4'd3,
        S_W_REV  = 4'd4,
        S_LD_PER = 4'd5,
        S_W_PER  = 4'd6,
        S_LD_ROT = 4'd7,
        S_W_ROT  = 4'd8,
        S_LD_PAR = 4'd9,
        S_W_PAR  = 4'd10,
        S_NEXT   = 4'd11,
        S_DONE   = 4'd12,
        S_ERR    = 4'd13
    } state_e;

    // Stage order within one decode round.
    typedef enum logic [2:0] {
        STG_RC  = 3'd0,
        STG_REV = 3'd1,
        STG_PER = 3'd2,
        STG_ROT = 3'd3,
        STG_PAR = 3'd4
    } stage_e;

    // True for the launch states of the five stages.
    function automatic logic is_ld(input state_e s);
        return (s inside {S_LD_RC, S_LD_REV, S_LD_PER, S_LD_ROT, S_LD_PAR});
    endfunction

    // True for any state where a stage unit is being driven or awaited.
    function automatic logic is_stage(input state_e s);
        return (s inside {S_LD_RC, S_W_RC, S_LD_REV, S_W_REV, S_LD_PER,
                          S_W_PER, S_LD_ROT, S_W_ROT, S_LD_PAR, S_W_PAR});
    endfunction

    // Launch step: the unit accepts by dropping ready; progress beats timeout.
    function automatic state_e ld_step(input logic rdy, input logic expired,
                                       input state_e cur, input state_e nxt);
        state_e r;
        if (!rdy) begin
            r = nxt;
        end else if (expired) begin
            r = S_ERR;
        end else begin
            r = cur;
        end
        return r;
    endfunction

    // Wait step: the unit finishes by raising ready; completion beats timeout.
    function automatic state_e w_step(input logic rdy, input logic expired,
                                      input state_e cur, input state_e nxt);
        state_e r;
        if (rdy) begin
            r = nxt;
        end else if (expired) begin
            r = S_ERR;
        end else begin
            r = cur;
        end
        return r;
    endfunction

endpackage

// File: rtl/decoder_controller_if.sv
// Handshake bundle between the decode sequencer and its five stage units.
interface decoder_controller_if #(
    parameter int RW = 5
);
    logic          start;
    logic          ready_rc;
    logic          ready_rev;
    logic          ready_per;
    logic          ready_rot;
    logic          ready_par;
    logic          start_rc;
    logic          start_rev;
    logic          start_per;
    logic          start_rot;
    logic          start_par;
    logic [RW-1:0] round_idx;
    logic          ready;
    logic          done;
    logic          err;
    logic [3:0]    ps;

    modport master (
        input  start, ready_rc, ready_rev, ready_per, ready_rot, ready_par,
        output start_rc, start_rev, start_per, start_rot, start_par,
               round_idx, ready, done, err, ps
    );

    modport slave (
        output start, ready_rc, ready_rev, ready_per, ready_rot, ready_par,
        input  start_rc, start_rev, start_per, start_rot, start_par,
               round_idx, ready, done, err, ps
    );
endinterface

// File: rtl/dec_round_cnt.sv
// Round index down-counter; loads the last round and stops at zero.
module dec_round_cnt #(
    parameter int            RW       = 5,
    parameter logic [RW-1:0] LOAD_VAL = 5'd23
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    output logic          zero,
    output logic [RW-1:0] q
);

    logic [RW-1:0] q_r;

    assign zero = (q_r == {RW{1'b0}});
    assign q    = q_r;

    // Counter register: reset/load to the last round, decrement without wrap.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r <= LOAD_VAL;
        end else if (load) begin
            q_r <= LOAD_VAL;
        end else if (dec && !zero) begin
            q_r <= q_r - {{(RW-1){1'b0}}, 1'b1};
        end else begin
            q_r <= q_r;
        end
    end

endmodule

// File: rtl/decoder_controller.sv
// Sequencer for the inverse permutation datapath: runs the five inverse
// stages per round, rounds counting down, with a per-stage watchdog.
module decoder_controller
    import decoder_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int RW         = 5,
    parameter int TO_W       = 8,
    parameter int TIMEOUT    = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_controller_if.master bus
);

    localparam logic [RW-1:0]   RIDX_LOAD = RW'(NUM_ROUNDS - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

    state_e          ps_r;
    state_e          ns_s;
    logic [TO_W-1:0] wd_r;
    logic            wd_exp_s;
    logic            cnt_load_s;
    logic            cnt_dec_s;
    logic            cnt_zero_s;
    logic [RW-1:0]   cnt_q_s;

    logic            ready_r;
    logic            done_r;
    logic            err_r;
    logic            start_rc_r;
    logic            start_rev_r;
    logic            start_per_r;
    logic            start_rot_r;
    logic            start_par_r;

    // A stage that has reached its last allowed cycle and cannot progress times out.
    assign wd_exp_s = (wd_r >= TO_LAST);

    dec_round_cnt #(
        .RW       (RW),
        .LOAD_VAL (RIDX_LOAD)
    ) u_round_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load_s),
        .dec  (cnt_dec_s),
        .zero (cnt_zero_s),
        .q    (cnt_q_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_r <= S_IDLE;
        end else begin
            ps_r <= ns_s;
        end
    end

    // Next-state logic and round counter controls.
    always_comb begin
        ns_s       = S_IDLE;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        case (ps_r)
            S_IDLE: begin
                if (bus.start) begin
                    ns_s       = S_LD_RC;
                    cnt_load_s = 1'b1;
                end else begin
                    ns_s = S_IDLE;
                end
            end
            S_LD_RC:  ns_s = ld_step(bus.ready_rc,  wd_exp_s, S_LD_RC,  S_W_RC);
            S_W_RC:   ns_s = w_step (bus.ready_rc,  wd_exp_s, S_W_RC,   S_LD_REV);
            S_LD_REV: ns_s = ld_step(bus.ready_rev, wd_exp_s, S_LD_REV, S_W_REV);
            S_W_REV:  ns_s = w_step (bus.ready_rev, wd_exp_s, S_W_REV,  S_LD_PER);
            S_LD_PER: ns_s = ld_step(bus.ready_per, wd_exp_s, S_LD_PER, S_W_PER);
            S_W_PER:  ns_s = w_step (bus.ready_per, wd_exp_s, S_W_PER,  S_LD_ROT);
            S_LD_ROT: ns_s = ld_step(bus.ready_rot, wd_exp_s, S_LD_ROT, S_W_ROT);
            S_W_ROT:  ns_s = w_step (bus.ready_rot, wd_exp_s, S_W_ROT,  S_LD_PAR);
            S_LD_PAR: ns_s = ld_step(bus.ready_par, wd_exp_s, S_LD_PAR, S_W_PAR);
            S_W_PAR:  ns_s = w_step (bus.ready_par, wd_exp_s, S_W_PAR,  S_NEXT);
            S_NEXT: begin
                if (cnt_zero_s) begin
                    ns_s = S_DONE;
                end else begin
                    ns_s      = S_LD_RC;
                    cnt_dec_s = 1'b1;
                end
            end
            S_DONE: ns_s = S_IDLE;
            S_ERR: begin
                if (bus.start) begin
                    ns_s       = S_LD_RC;
                    cnt_load_s = 1'b1;
                end else begin
                    ns_s = S_ERR;
                end
            end
            default: ns_s = S_IDLE;
        endcase
    end

    // Watchdog: restarts on every stage launch, counts through launch and wait.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_r <= {TO_W{1'b0}};
        end else if (is_ld(ns_s) && (ns_s != ps_r)) begin
            wd_r <= {TO_W{1'b0}};
        end else if (is_stage(ps_r)) begin
            wd_r <= wd_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            wd_r <= {TO_W{1'b0}};
        end
    end

    // Moore outputs registered from the next state so they track ps exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            start_rc_r  <= 1'b0;
            start_rev_r <= 1'b0;
            start_per_r <= 1'b0;
            start_rot_r <= 1'b0;
            start_par_r <= 1'b0;
        end else begin
            ready_r     <= (ns_s == S_IDLE);
            done_r      <= (ns_s == S_DONE);
            err_r       <= (ns_s == S_ERR);
            start_rc_r  <= (ns_s == S_LD_RC);
            start_rev_r <= (ns_s == S_LD_REV);
            start_per_r <= (ns_s == S_LD_PER);
            start_rot_r <= (ns_s == S_LD_ROT);
            start_par_r <= (ns_s == S_LD_PAR);
        end
    end

    assign bus.ready     = ready_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.start_rc  = start_rc_r;
    assign bus.start_rev = start_rev_r;
    assign bus.start_per = start_per_r;
    assign bus.start_rot = start_rot_r;
    assign bus.start_par = start_par_r;
    assign bus.round_idx = cnt_q_s;
    assign bus.ps        = ps_r;

endmodule
